// File: rtl/vga_cap_pkg.sv
// Shared definitions for the receive-side character capture path: FSM encoding,
// default 640x480 timing and the 16x16 box window lookup.
package vga_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int H_VIS_START = 144;
  localparam int V_VIS_START = 35;
  localparam int BOX_DIM     = 16;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [3:0] col;
  } box_hit_t;

  // Unsigned wrap of the offsets means positions left of or above the origin miss.
  function automatic box_hit_t box_lookup(input logic [9:0] h, input logic [9:0] v,
                                          input logic [9:0] x, input logic [9:0] y);
    logic [9:0] dc;
    logic [9:0] dr;
    box_hit_t   r;
    dc    = h - x;
    dr    = v - y;
    r.hit = (dc < 10'(BOX_DIM)) && (dr < 10'(BOX_DIM));
    r.col = dc[3:0];
    r.row = dr[3:0];
    return r;
  endfunction

endpackage

// File: rtl/sync_recover.sv
// Recovers pixel/line counters from HS/VS edges and tracks whether the stream
// timing matches the expected line and frame totals.
module sync_recover #(
  parameter int   H_TOTAL  = 800,
  parameter int   V_TOTAL  = 525,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       pix_clk,
  input  logic       rst,
  input  logic       hs,
  input  logic       vs,
  output logic       hs_edge,
  output logic       vs_edge,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       locked
);

  localparam logic [10:0] H_T = 11'(H_TOTAL);
  localparam logic [10:0] V_T = 11'(V_TOTAL);

  logic       hs_q;
  logic       vs_q;
  logic       seen_hs;
  logic       line_bad;
  logic       line_bad_now;
  logic       frame_ok;
  logic [1:0] good_cnt;

  assign hs_edge = (hs == SYNC_POL) && (hs_q != SYNC_POL);
  assign vs_edge = (vs == SYNC_POL) && (vs_q != SYNC_POL);

  // The line ending on the first hs_edge after reset is partial, so it is not judged.
  assign line_bad_now = line_bad |
                        (hs_edge && seen_hs && (({1'b0, h_cnt} + 11'd1) != H_T));
  assign frame_ok     = !line_bad_now && (({1'b0, v_cnt} + 11'd1) == V_T);

  always_ff @(posedge pix_clk) begin
    if (!rst) begin
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      h_cnt    <= '0;
      v_cnt    <= '0;
      seen_hs  <= 1'b0;
      line_bad <= 1'b0;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;

      if (hs_edge)            h_cnt <= '0;
      else if (h_cnt != '1)   h_cnt <= h_cnt + 10'd1;

      if (vs_edge)                     v_cnt <= '0;
      else if (hs_edge && v_cnt != '1) v_cnt <= v_cnt + 10'd1;

      if (hs_edge) seen_hs <= 1'b1;

      if (vs_edge) begin
        line_bad <= 1'b0;
        if (frame_ok) begin
          if (good_cnt != 2'd2) good_cnt <= good_cnt + 2'd1;
          if (good_cnt != 2'd0) locked   <= 1'b1;
        end else begin
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end else begin
        line_bad <= line_bad_now;
      end
    end
  end

endmodule

// File: rtl/vga_char_capture.sv
// Captures one 16x16 character box from a full received frame into a bit
// buffer that can be read back row by row for comparison against the font ROM.
module vga_char_capture
  import vga_cap_pkg::*;
#(
  parameter int         H_TOTAL  = vga_cap_pkg::H_TOTAL,
  parameter int         V_TOTAL  = vga_cap_pkg::V_TOTAL,
  parameter logic       SYNC_POL = 1'b0,
  parameter logic [7:0] THRESH   = 8'd128
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        HS_in,
  input  logic        VS_in,
  input  logic        VA_in,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic        arm,
  input  logic [3:0]  rd_row,
  output logic [15:0] rd_data,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        locked,
  output logic        busy,
  output logic        done,
  output logic        cap_err
);

  cap_state_e                             state;
  logic [BOX_DIM-1:0][BOX_DIM-1:0]        buffer;
  logic                                   hs_edge;
  logic                                   vs_edge;
  logic                                   pix_bit;
  box_hit_t                               box;
  logic                                   unused_chan;

  sync_recover #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .SYNC_POL (SYNC_POL)
  ) u_sync (
    .pix_clk (pix_clk),
    .rst     (rst),
    .hs      (HS_in),
    .vs      (VS_in),
    .hs_edge (hs_edge),
    .vs_edge (vs_edge),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .locked  (locked)
  );

  // Only red drives the 1/0 decision; the other channels are sampled for completeness.
  assign unused_chan = ^{green_in, blue_in, hs_edge};

  assign box     = box_lookup(h_cnt, v_cnt, x_pos, y_pos);
  assign pix_bit = VA_in && (red_in >= THRESH);
  assign busy    = (state == WAIT_VS) || (state == CAPTURE);

  always_ff @(posedge pix_clk) begin
    if (!rst) begin
      state   <= IDLE;
      buffer  <= '0;
      rd_data <= '0;
      done    <= 1'b0;
      cap_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_data <= buffer[rd_row];
      case (state)
        IDLE: begin
          if (arm) state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (vs_edge) begin
            buffer  <= '0;
            cap_err <= 1'b0;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Bit 15 holds the leftmost pixel so rows line up with font ROM words.
          if (box.hit) begin
            buffer[box.row][4'd15 - box.col] <= pix_bit;
            if (!VA_in) cap_err <= 1'b1;
          end
          if (vs_edge) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
